// File: rtl/wormhole_port_allocator_if.sv
`default_nettype none
// ============================================================================
// Module   : wormhole_port_allocator_if
// Brief    : Request/flit/credit inputs and grant/status outputs of one
//            router output-port allocator.
// Revision : 1.0
// ============================================================================
interface wormhole_port_allocator_if #(
    parameter int CREDITS = 4
) ();
    logic [4:0]                     req;
    logic [14:0]                    flit_id;
    logic                           credit_in;
    logic [4:0]                     grant;
    logic [2:0]                     sel;
    logic                           xfer;
    logic [$clog2(CREDITS+1)-1:0]   credits;
    logic                           timeout;

    // Route computation / downstream side
    modport master (
        output req, flit_id, credit_in,
        input  grant, sel, xfer, credits, timeout
    );

    // Allocator side
    modport slave (
        input  req, flit_id, credit_in,
        output grant, sel, xfer, credits, timeout
    );
endinterface
`default_nettype wire

// File: rtl/wormhole_port_allocator.sv
`default_nettype none
// ============================================================================
// Module   : wormhole_port_allocator
// Brief    : Round-robin wormhole allocator for one output shared by five
//            inputs, with credit flow control and a stall watchdog.
// Revision : 1.0
// ============================================================================
module wormhole_port_allocator #(
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 255
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    wormhole_port_allocator_if.slave        bus
);
    localparam int              CW           = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]   C_CRED_MAX   = CW'(CREDITS);
    localparam logic [11:0]     C_STALL_LAST = 12'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      last_q,  last_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic [11:0]     stall_q, stall_d;
    logic            timeout_q, timeout_d;

    logic [2:0]      w_winner;
    logic [2:0]      w_flit;
    logic            w_xfer;

    // Descending scan so the port closest after last_q is assigned last and wins
    always_comb begin
        w_winner = 3'd0;
        for (int k = 5; k >= 1; k--) begin
            int idx;
            idx = (int'(last_q) + k) % 5;
            if (bus.req[3'(idx)]) begin
                w_winner = 3'(idx);
            end
        end
    end

    assign w_flit = bus.flit_id[{1'b0, owner_q} * 4'd3 +: 3];
    assign w_xfer = (state_q == ST_LOCKED) && bus.req[owner_q] && (credits_q != '0);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        credits_d = credits_q;
        stall_d   = stall_q;
        timeout_d = 1'b0;

        // A simultaneous consume and return leaves the count unchanged
        if (w_xfer && !bus.credit_in) begin
            credits_d = credits_q - 1'b1;
        end else if (bus.credit_in && !w_xfer && (credits_q != C_CRED_MAX)) begin
            credits_d = credits_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                stall_d = 12'd0;
                if (bus.req != 5'd0) begin
                    state_d = ST_LOCKED;
                    owner_d = w_winner;
                end
            end
            ST_LOCKED: begin
                if (w_xfer) begin
                    stall_d = 12'd0;
                    if (w_flit[2]) begin
                        state_d = ST_IDLE;
                        last_d  = owner_q;
                    end
                end else if (stall_q == C_STALL_LAST) begin
                    state_d   = ST_IDLE;
                    last_d    = owner_q;
                    stall_d   = 12'd0;
                    timeout_d = 1'b1;
                end else begin
                    stall_d = stall_q + 12'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 3'd0;
            last_q    <= 3'd4;
            credits_q <= C_CRED_MAX;
            stall_q   <= 12'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            credits_q <= credits_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant   = (state_q == ST_LOCKED) ? (5'd1 << owner_q) : 5'd0;
    assign bus.sel     = (state_q == ST_LOCKED) ? owner_q : 3'd0;
    assign bus.xfer    = w_xfer;
    assign bus.credits = credits_q;
    assign bus.timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_wormhole_port_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_wormhole_port_allocator
// Brief    : Directed scenarios plus random traffic against a packet-level model.
// Revision : 1.0
// ============================================================================
module tb_wormhole_port_allocator;
    localparam int CREDITS = 4;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wormhole_port_allocator_if #(.CREDITS(CREDITS)) bus ();

    wormhole_port_allocator #(.CREDITS(CREDITS), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model: who holds the output, credit count, idle-stall age
    int m_locked, m_owner, m_last, m_cred, m_stall, m_to;
    int n_cmp = 0;
    int n_bad = 0;
    int rot_got[10];
    int rot_exp[10];

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_last = 4;
        m_cred = CREDITS; m_stall = 0; m_to = 0;
    endtask

    function automatic logic [14:0] fl(input int port, input logic [2:0] t);
        logic [14:0] v;
        v = 15'(t) << (3 * port);
        return v;
    endfunction

    // Drive one cycle's inputs at negedge, check outputs, advance the model
    task automatic step(input logic r, input logic [4:0] q, input logic [14:0] f, input logic ci);
        int ex;
        int found;
        rst = r; bus.req = q; bus.flit_id = f; bus.credit_in = ci;
        #1;
        ex = (m_locked != 0 && q[m_owner] && m_cred != 0) ? 1 : 0;
        cmp("grant",   int'(bus.grant),   m_locked ? (1 << m_owner) : 0);
        cmp("sel",     int'(bus.sel),     m_locked ? m_owner : 0);
        cmp("credits", int'(bus.credits), m_cred);
        cmp("timeout", int'(bus.timeout), m_to);
        cmp("xfer",    int'(bus.xfer),    ex);
        if (r) begin
            model_reset();
        end else begin
            if (ex != 0 && !ci) m_cred--;
            else if (ci && ex == 0 && m_cred < CREDITS) m_cred++;
            m_to = 0;
            if (m_locked == 0) begin
                found = 0;
                for (int k = 1; k <= 5; k++) begin
                    if (found == 0 && q[(m_last + k) % 5]) begin
                        found = 1;
                        m_owner = (m_last + k) % 5;
                    end
                end
                if (found != 0) begin
                    m_locked = 1;
                    m_stall = 0;
                end
            end else if (ex != 0) begin
                m_stall = 0;
                if (f[3 * m_owner + 2]) begin
                    m_locked = 0;
                    m_last = m_owner;
                end
            end else if (m_stall == TIMEOUT - 1) begin
                m_locked = 0; m_last = m_owner; m_stall = 0; m_to = 1;
            end else begin
                m_stall++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [2:0]  types [4];
        logic [4:0]  rq;
        logic [14:0] rf;
        types[0] = 3'b001; types[1] = 3'b010; types[2] = 3'b100; types[3] = 3'b101;
        rot_exp = '{1, 0, 2, 0, 4, 0, 8, 0, 16, 0};
        bus.req = '0; bus.flit_id = '0; bus.credit_in = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state, then an L packet of three flits
        step(1'b1, 5'b00000, 15'd0, 1'b0);
        step(1'b0, 5'b00001, fl(0, 3'b001), 1'b0);
        cmp("s1_grantL", int'(bus.grant), 1);
        step(1'b0, 5'b00001, fl(0, 3'b001), 1'b0);
        step(1'b0, 5'b00001, fl(0, 3'b010), 1'b0);
        step(1'b0, 5'b00001, fl(0, 3'b100), 1'b0);
        cmp("s1_credits", int'(bus.credits), 1);
        cmp("s1_idle", int'(bus.grant), 0);

        // Rotation from reset with single-flit packets and constant credit return
        step(1'b1, 5'b00000, 15'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'b11111, {5{3'b101}}, 1'b1);
            rot_got[i] = int'(bus.grant);
        end
        for (int i = 0; i < 10; i++) cmp("s2_rotation", rot_got[i], rot_exp[i]);

        // N drains all credits, then stalls into the watchdog
        step(1'b0, 5'b00010, fl(1, 3'b001), 1'b0);
        step(1'b0, 5'b00010, fl(1, 3'b001), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 5'b00010, fl(1, 3'b010), 1'b0);
        cmp("s3_cred0", int'(bus.credits), 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 5'b00010, fl(1, 3'b010), 1'b0);
        cmp("s3_not_yet", int'(bus.timeout), 0);
        step(1'b0, 5'b00010, fl(1, 3'b010), 1'b0);
        cmp("s3_timeout", int'(bus.timeout), 1);
        cmp("s3_released", int'(bus.grant), 0);
        step(1'b0, 5'b00100, fl(2, 3'b001), 1'b0);
        cmp("s3_timeout_once", int'(bus.timeout), 0);
        cmp("s3_grantE", int'(bus.grant), 5'b00100);

        // Credit return colliding with a transfer, and saturation
        step(1'b0, 5'b00000, 15'd0, 1'b1);
        step(1'b0, 5'b00000, 15'd0, 1'b1);
        step(1'b0, 5'b00100, fl(2, 3'b010), 1'b1);
        cmp("s4_both", int'(bus.credits), 2);
        for (int i = 0; i < 3; i++) step(1'b0, 5'b00000, 15'd0, 1'b1);
        cmp("s4_sat", int'(bus.credits), 4);
        step(1'b0, 5'b00100, fl(2, 3'b100), 1'b1);

        // W mid-packet hit by reset
        step(1'b0, 5'b01000, fl(3, 3'b001), 1'b0);
        step(1'b0, 5'b01000, fl(3, 3'b001), 1'b0);
        step(1'b1, 5'b01000, fl(3, 3'b010), 1'b0);
        cmp("s5_grant", int'(bus.grant), 0);
        cmp("s5_credits", int'(bus.credits), 4);
        step(1'b0, 5'b11111, {5{3'b101}}, 1'b0);
        cmp("s5_first_L", int'(bus.grant), 1);

        // E holds the output through a 4-flit packet while N and S wait
        step(1'b1, 5'b00000, 15'd0, 1'b0);
        step(1'b0, 5'b00100, fl(2, 3'b001), 1'b0);
        step(1'b0, 5'b10110, fl(2, 3'b001), 1'b1);
        step(1'b0, 5'b10110, fl(2, 3'b010), 1'b1);
        step(1'b0, 5'b10110, fl(2, 3'b010), 1'b1);
        cmp("s6_holdE", int'(bus.grant), 5'b00100);
        step(1'b0, 5'b10110, fl(2, 3'b100), 1'b1);
        step(1'b0, 5'b10010, {5{3'b101}}, 1'b1);
        cmp("s6_nextS", int'(bus.grant), 5'b10000);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rq = '0;
            rf = '0;
            for (int p = 0; p < 5; p++) begin
                rq[p] = ($urandom_range(0, 9) < 6);
                rf = rf | fl(p, types[$urandom_range(0, 3)]);
            end
            step(($urandom_range(0, 499) == 0), rq, rf, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
